// File: rtl/operand_fetch_unit_if.sv
// Bundle of issue, operand, writeback and register-file signals for operand_fetch_unit.
// The master side is the fetch unit; the slave side is the surrounding datapath.
interface operand_fetch_unit_if #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic                      iss_valid;
    logic                      iss_ready;
    logic [REG_ADDR_WIDTH-1:0] iss_rs1;
    logic [REG_ADDR_WIDTH-1:0] iss_rs2;
    logic [REG_ADDR_WIDTH-1:0] iss_rd;
    logic                      iss_rd_en;

    logic                      op_valid;
    logic                      op_ready;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic [REG_ADDR_WIDTH-1:0] op_rd;
    logic                      op_rd_en;

    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic [REG_ADDR_WIDTH-1:0] rf_reg1;
    logic [REG_ADDR_WIDTH-1:0] rf_reg2;
    logic [DATA_WIDTH-1:0]     rf_data1;
    logic [DATA_WIDTH-1:0]     rf_data2;
    logic                      rf_write_en;
    logic [REG_ADDR_WIDTH-1:0] rf_regw;
    logic [DATA_WIDTH-1:0]     rf_dataw;

    logic [NUM_REGS-1:0]       busy_mask;

    modport master (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        output iss_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_en,
        input  op_ready,
        input  wb_valid, wb_rd, wb_data,
        output rf_reg1, rf_reg2, rf_write_en, rf_regw, rf_dataw,
        input  rf_data1, rf_data2,
        output busy_mask
    );

    modport slave (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_en,
        input  iss_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_en,
        output op_ready,
        output wb_valid, wb_rd, wb_data,
        input  rf_reg1, rf_reg2, rf_write_en, rf_regw, rf_dataw,
        output rf_data1, rf_data2,
        input  busy_mask
    );
endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch: reads the register file for an issued instruction, stalls on pending
// destinations, forwards same-cycle writeback data and holds operands in one output slot.
module operand_fetch_unit #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8
) (
    input logic                 clk,
    input logic                 rst,
    operand_fetch_unit_if.master bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0]       pending;
    logic [NUM_REGS-1:0]       clr;
    logic [NUM_REGS-1:0]       set_v;
    logic [NUM_REGS-1:0]       pend_eff;
    logic                      hazard;
    logic                      iss_ready;
    logic                      accept;
    logic [DATA_WIDTH-1:0]     fwd_a;
    logic [DATA_WIDTH-1:0]     fwd_b;

    logic                      op_valid_q;
    logic [DATA_WIDTH-1:0]     op_a_q;
    logic [DATA_WIDTH-1:0]     op_b_q;
    logic [REG_ADDR_WIDTH-1:0] op_rd_q;
    logic                      op_rd_en_q;

    assign bus.rf_reg1     = bus.iss_rs1;
    assign bus.rf_reg2     = bus.iss_rs2;
    assign bus.rf_write_en = bus.wb_valid;
    assign bus.rf_regw     = bus.wb_rd;
    assign bus.rf_dataw    = bus.wb_data;

    always_comb begin
        clr   = '0;
        set_v = '0;
        if (bus.wb_valid)
            clr[bus.wb_rd] = 1'b1;
        if (accept && bus.iss_rd_en)
            set_v[bus.iss_rd] = 1'b1;
    end

    // A register being written back this cycle no longer blocks issue.
    assign pend_eff  = pending & ~clr;
    assign hazard    = pend_eff[bus.iss_rs1] | pend_eff[bus.iss_rs2] |
                       (bus.iss_rd_en & pend_eff[bus.iss_rd]);
    assign iss_ready = !hazard && (!op_valid_q || bus.op_ready);
    assign accept    = bus.iss_valid && iss_ready;

    assign fwd_a = clr[bus.iss_rs1] ? bus.wb_data : bus.rf_data1;
    assign fwd_b = clr[bus.iss_rs2] ? bus.wb_data : bus.rf_data2;

    // Set is ORed after the clear so a same-cycle reissue keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~clr) | set_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_rd_en_q <= 1'b0;
        end else if (accept) begin
            op_valid_q <= 1'b1;
            op_a_q     <= fwd_a;
            op_b_q     <= fwd_b;
            op_rd_q    <= bus.iss_rd;
            op_rd_en_q <= bus.iss_rd_en;
        end else if (bus.op_ready) begin
            op_valid_q <= 1'b0;
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.op_rd     = op_rd_q;
    assign bus.op_rd_en  = op_rd_en_q;
    assign bus.busy_mask = pending;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed and randomized checks of operand_fetch_unit against an architectural model.
module tb_operand_fetch_unit;
    logic clk;
    logic rst;
    logic rf_init;

    operand_fetch_unit_if #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    operand_fetch_unit #(.REG_ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment register file: combinational read, write on the rising edge.
    logic [7:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
        end else if (bus.rf_write_en) begin
            rf_mem[bus.rf_regw] <= bus.rf_dataw;
        end
    end
    assign bus.rf_data1 = rf_mem[bus.rf_reg1];
    assign bus.rf_data2 = rf_mem[bus.rf_reg2];

    // Architectural model: register values, pending set and the single operand slot.
    logic [7:0] mrf [16];
    bit         m_pend [16];
    bit         m_valid;
    logic [7:0] m_a, m_b;
    logic [3:0] m_rd;
    bit         m_rden;

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit rden,
                         input bit wbv, input int wbrd, input int wbd, input bit opr);
        bus.iss_valid = v;
        bus.iss_rs1   = 4'(rs1);
        bus.iss_rs2   = 4'(rs2);
        bus.iss_rd    = 4'(rd);
        bus.iss_rd_en = rden;
        bus.wb_valid  = wbv;
        bus.wb_rd     = 4'(wbrd);
        bus.wb_data   = 8'(wbd);
        bus.op_ready  = opr;
    endtask

    function automatic bit blocked(input logic [3:0] r);
        return m_pend[r] && !(bus.wb_valid && bus.wb_rd == r);
    endfunction

    function automatic logic [7:0] value_of(input logic [3:0] r);
        return (bus.wb_valid && bus.wb_rd == r) ? bus.wb_data : mrf[r];
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = m_pend[i];
        return m;
    endfunction

    task automatic check_outputs();
        check("op_valid", bus.op_valid, m_valid);
        check("busy_mask", bus.busy_mask, model_mask());
        check("op_a", bus.op_a, m_a);
        check("op_b", bus.op_b, m_b);
        check("op_rd", bus.op_rd, m_rd);
        check("op_rd_en", bus.op_rd_en, m_rden);
    endtask

    // One clock: check combinational outputs, advance model across the edge, check state.
    task automatic cycle();
        bit hz, er, acc;
        logic [7:0] na, nb;
        #2;
        hz = blocked(bus.iss_rs1) || blocked(bus.iss_rs2) || (bus.iss_rd_en && blocked(bus.iss_rd));
        er = !hz && (!m_valid || bus.op_ready);
        check("iss_ready", bus.iss_ready, er);
        check("rf_reg1", bus.rf_reg1, bus.iss_rs1);
        check("rf_reg2", bus.rf_reg2, bus.iss_rs2);
        check("rf_write_en", bus.rf_write_en, bus.wb_valid);
        if (bus.wb_valid) begin
            check("rf_regw", bus.rf_regw, bus.wb_rd);
            check("rf_dataw", bus.rf_dataw, bus.wb_data);
        end
        acc = bus.iss_valid && er;
        na  = value_of(bus.iss_rs1);
        nb  = value_of(bus.iss_rs2);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_a = na;
            m_b = nb;
            m_rd = bus.iss_rd;
            m_rden = bus.iss_rd_en;
        end else if (bus.op_ready) begin
            m_valid = 1'b0;
        end
        if (bus.wb_valid) begin
            m_pend[bus.wb_rd] = 1'b0;
            mrf[bus.wb_rd] = bus.wb_data;
        end
        if (acc && bus.iss_rd_en) m_pend[bus.iss_rd] = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_rd = 4'h0;
        m_rden = 1'b0;
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        rf_init = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        for (int i = 0; i < 16; i++) mrf[i] = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        rf_init = 1'b0;
        rst = 1'b0;

        // Write then read with a 1-cycle issue-to-operand latency
        drive(0, 0, 0, 0, 0, 1, 1, 8'hFF, 1); cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1);     cycle();
        check("wr_rd_op_a", bus.op_a, 8'hFF);
        check("wr_rd_op_b", bus.op_b, 8'h00);

        // RAW stall for three cycles, then zero-bubble forward
        drive(1, 0, 0, 3, 1, 0, 0, 0, 1); cycle();
        check("raw_busy3", bus.busy_mask, 16'h0008);
        drive(1, 3, 0, 6, 0, 0, 0, 0, 1);
        repeat (3) cycle();
        drive(1, 3, 0, 6, 0, 1, 3, 8'h5A, 1); cycle();
        check("raw_fwd_op_a", bus.op_a, 8'h5A);
        check("raw_busy_clear", bus.busy_mask, 16'h0000);

        // Backpressure: entry holds until op_ready, then replaced the same cycle
        drive(0, 0, 0, 0, 0, 1, 4, 8'h11, 1); cycle();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);     cycle();
        drive(1, 0, 4, 0, 0, 0, 0, 0, 0);     cycle(); cycle();
        check("bp_hold_op_a", bus.op_a, 8'h11);
        drive(1, 0, 4, 0, 0, 0, 0, 0, 1);     cycle();
        check("bp_new_op_b", bus.op_b, 8'h11);

        // Same-cycle set and clear of one register: set wins
        drive(1, 0, 0, 2, 1, 0, 0, 0, 1);     cycle();
        drive(1, 0, 0, 2, 1, 1, 2, 8'h22, 1); cycle();
        check("setclr_busy2", bus.busy_mask[2], 1'b1);

        // WAW stall on reg 5, released by its writeback
        drive(1, 0, 0, 5, 1, 0, 0, 0, 1);     cycle();
        drive(1, 0, 0, 5, 1, 0, 0, 0, 1);     cycle(); cycle();
        drive(1, 0, 0, 5, 1, 1, 5, 8'h55, 1); cycle();
        check("waw_busy5", bus.busy_mask[5], 1'b1);

        // Reset mid-operation with a writeback in the reset cycle
        drive(0, 0, 0, 0, 0, 1, 2, 8'h02, 1); cycle();
        drive(0, 0, 0, 0, 0, 1, 5, 8'h05, 1); cycle();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0);     cycle();
        check("pre_rst_busy", bus.busy_mask, 16'h0008);
        drive(0, 0, 0, 0, 0, 1, 7, 8'h77, 0);
        rst = 1'b1;
        #1;
        check("rst_op_valid", bus.op_valid, 1'b0);
        check("rst_busy", bus.busy_mask, 16'h0000);
        check("rst_op_a", bus.op_a, 8'h00);
        check("rst_rf_we", bus.rf_write_en, 1'b1);
        model_reset();
        @(posedge clk);
        mrf[7] = 8'h77;
        #1;
        rst = 1'b0;
        drive(1, 7, 7, 0, 0, 0, 0, 0, 1); cycle();
        check("post_rst_op_a", bus.op_a, 8'h77);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, r, $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Register-file initiator for the cpu_01 datapath. Accepts decoded instructions (source and destination register numbers) through a valid/ready handshake and drives the register file's two read ports. It captures both operands into a one-entry output stage and drives the register file's write port from the writeback bus. A per-register pending scoreboard stalls issue on RAW/WAW hazards, and same-cycle writeback data is forwarded to the captured operands.

## Interface
- REG_ADDR_WIDTH, 4, register address width; NUM_REGS = 2**REG_ADDR_WIDTH
- DATA_WIDTH, 8, register data width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  instruction offered
- iss_ready  out  1  instruction accepted this cycle when iss_valid is also high
- iss_rs1, iss_rs2  in  REG_ADDR_WIDTH  source register numbers
- iss_rd  in  REG_ADDR_WIDTH  destination register number
- iss_rd_en  in  1  instruction will write iss_rd
- op_valid  out  1  operand stage holds a valid entry
- op_ready  in  1  downstream consumes the entry
- op_a, op_b  out  DATA_WIDTH  captured operands for rs1 and rs2
- op_rd  out  REG_ADDR_WIDTH  captured destination
- op_rd_en  out  1  captured destination enable
- wb_valid  in  1  writeback request; always accepted, no ready
- wb_rd  in  REG_ADDR_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback data
- rf_reg1, rf_reg2  out  REG_ADDR_WIDTH  register file read addresses
- rf_data1, rf_data2  in  DATA_WIDTH  register file read data; combinational from rf_reg1/rf_reg2
- rf_write_en  out  1  register file write enable; register file writes on the rising clk edge
- rf_regw  out  REG_ADDR_WIDTH  register file write address
- rf_dataw  out  DATA_WIDTH  register file write data
- busy_mask  out  NUM_REGS  pending bit per register

## Operation
- Read path is combinational:
  - rf_reg1 = iss_rs1
  - rf_reg2 = iss_rs2
- Write path is combinational pass-through:
  - rf_write_en = wb_valid
  - rf_regw = wb_rd
  - rf_dataw = wb_data
- clr[r] = wb_valid && wb_rd == r. pend_eff[r] = pending[r] && !clr[r].
- hazard = pend_eff[iss_rs1] || pend_eff[iss_rs2] || (iss_rd_en && pend_eff[iss_rd]).
- iss_ready = !hazard && (!op_valid || op_ready). iss_ready is combinational from the iss_* fields, wb_*, and state. It does not depend on iss_valid.
- On accept (iss_valid && iss_ready):
  - op_a <= clr[iss_rs1] ? wb_data : rf_data1
  - op_b <= clr[iss_rs2] ? wb_data : rf_data2
  - op_rd <= iss_rd, op_rd_en <= iss_rd_en, op_valid <= 1
- Output stage:
  - Entry consumed with no new accept: op_valid <= 0.
  - op_valid && !op_ready: op_a, op_b, op_rd and op_rd_en hold.
- Scoreboard update per edge:
  - pending[r] cleared when clr[r].
  - pending[r] set when accept && iss_rd_en && iss_rd == r.
  - Set and clear of the same register in the same cycle: set wins.
- Writeback to a non-pending register is written normally; the scoreboard is unchanged.
- rs1 == rs2 is legal; both operands receive the same value.
- Register 0 is an ordinary register with no hardwired zero.
- busy_mask = pending, registered.

## Timing
- Reset values (asynchronous, immediate on rst):
  - op_valid = 0
  - op_a = op_b = 0
  - op_rd = 0, op_rd_en = 0
  - pending = 0, so busy_mask = 0
  - iss_ready follows its equation: 1 after reset when op_ready is irrelevant (op_valid = 0) and no hazard exists
- Reset mid-operation discards the held operand entry and all pending bits. A writeback in the reset cycle still reaches the rf_* pins combinationally.
- Issue-to-operand latency is 1 cycle: accept at edge N, op_valid high after edge N.
- Throughput is 1 instruction per cycle while op_ready = 1 and no hazard.
- Hazard release is zero-bubble: the cycle wb_valid clears the blocking register, iss_ready rises and the forwarded wb_data is captured.
- Back-to-back dependent pair (second reads the first's rd) stalls until that rd's writeback cycle.

## Test plan
- Reset: run traffic, assert rst while op_valid = 1 and busy_mask = 16'h0008 -> op_valid = 0, busy_mask = 0, op_a = 0 immediately. After release, a 1-cycle issue is accepted.
- Write then read: wb_valid, wb_rd = 1, wb_data = 8'hFF; next cycle issue rs1 = 1, rs2 = 0 -> rf_write_en pulses with rf_regw = 1, then op_a = 8'hFF, op_b = 8'h00, op_valid = 1 one cycle after accept.
- RAW stall and forward: issue rd = 3, rd_en = 1 (busy_mask[3] = 1); issue rs1 = 3 -> iss_ready = 0 for 3 cycles. Then wb rd = 3, data = 8'h5A -> iss_ready = 1 that cycle, op_a = 8'h5A, busy_mask[3] = 0.
- Backpressure: op_ready = 0 with entry op_a = 8'h11; offer a second instruction -> iss_ready = 0 and op_a holds 8'h11. Raise op_ray = 1 -> second accepted the same cycle, op_valid stays 1 with the new operands.
- Simultaneous set/clear: busy_mask[2] = 1; same cycle wb rd = 2 and issue rd = 2, rd_en = 1 -> accepted, busy_mask[2] remains 1.
- WAW: busy_mask[5] = 1; issue rd = 5, rs1 = 0, rs2 = 0 -> stalled until wb rd = 5. Accepted that cycle with busy_mask[5] = 1.
